mem_buffer_ctrl: RTL and testbench

Single-clock controller that sequences the Rx and Tx byte RAMs of the upgrade link's Memory block.
- Rx side: packs an incoming byte stream (UART receiver) into RxRAM and presents each completed frame to the command engine, which reads RxRAM directly.
- Tx side: on request, streams a response the command engine has already written into TxRAM out to the UART transmitter with a valid/ready handshake.
- Sits between the UART, the Memory block and the command engine.

---
 rtl/mem_buffer_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_buffer_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_buffer_ctrl.sv
// Rx/Tx buffer sequencer for the upgrade link Memory block.
// Rx packs UART bytes into RxRAM frames; Tx streams TxRAM bytes out with valid/ready.
module mem_buffer_ctrl #(
  parameter  int NUMBER = 256,
  localparam int AW     = $clog2(NUMBER),
  localparam int LW     = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          rx_last,
  output logic [7:0]    wr_rx_data,
  output logic [AW-1:0] wr_rx_addr,
  output logic          we_rx,
  output logic          frame_ready,
  output logic [LW-1:0] frame_len,
  input  logic          frame_ack,
  output logic          rx_drop,
  output logic          rx_overflow,
  input  logic          tx_start,
  input  logic [LW-1:0] tx_len,
  output logic [AW-1:0] rd_tx_addr,
  input  logic [7:0]    rd_tx_data,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          dbg_rx_state,
  output logic [1:0]    dbg_tx_state
);

  // Handshake: a Tx byte transfers on a rising clock edge where tx_valid && tx_ready;
  // tx_valid and tx_data hold steady until that edge and tx_valid never depends on tx_ready.

  typedef enum logic {RX_FILL = 1'b0, RX_HOLD = 1'b1} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_ADDR, TX_DATA, TX_OUT} tx_state_t;

  rx_state_t     r_rx_state, w_rx_next;
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_frame_len;
  logic          r_frame_ready;
  logic          r_rx_drop;
  logic          r_rx_overflow;
  logic          w_rx_write;
  logic          w_wrap;

  // Write strobe is combinational from rx_valid, gated so outputs read 0 while in reset.
  assign w_rx_write  = rx_valid && (r_rx_state == RX_FILL) && !reset;
  assign w_wrap      = (r_wr_ptr == AW'(NUMBER - 1));
  assign we_rx       = w_rx_write;
  assign wr_rx_addr  = r_wr_ptr;
  assign wr_rx_data  = w_rx_write ? rx_data : 8'h00;
  assign frame_ready = r_frame_ready;
  assign frame_len   = r_frame_len;
  assign rx_drop     = r_rx_drop;
  assign rx_overflow = r_rx_overflow;
  assign dbg_rx_state = r_rx_state;

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_FILL: if (rx_valid && rx_last) w_rx_next = RX_HOLD;
      RX_HOLD: if (frame_ack)           w_rx_next = RX_FILL;
      default: w_rx_next = RX_FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_state    <= RX_FILL;
      r_wr_ptr      <= '0;
      r_frame_len   <= '0;
      r_frame_ready <= 1'b0;
      r_rx_drop     <= 1'b0;
      r_rx_overflow <= 1'b0;
    end else begin
      r_rx_state    <= w_rx_next;
      r_rx_drop     <= 1'b0;
      r_rx_overflow <= 1'b0;
      if (w_rx_write) begin
        if (rx_last) begin
          r_frame_len   <= LW'(r_wr_ptr) + 1'b1;
          r_frame_ready <= 1'b1;
          r_wr_ptr      <= '0;
        end else begin
          // Pointer wraps by width; a wrap without rx_last discards the partial frame.
          r_wr_ptr      <= r_wr_ptr + 1'b1;
          r_rx_overflow <= w_wrap;
        end
      end
      if (r_rx_state == RX_HOLD) begin
        r_rx_drop <= rx_valid;
        if (frame_ack) r_frame_ready <= 1'b0;
      end
    end
  end

  tx_state_t     r_tx_state, w_tx_next;
  logic [LW-1:0] r_tx_len;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_rd_addr;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic          r_tx_busy;
  logic          r_tx_done;
  logic          w_accept;
  logic          w_last;

  assign w_accept     = r_tx_valid && tx_ready;
  assign w_last       = ({1'b0, r_idx} == (r_tx_len - 1'b1));
  assign rd_tx_addr   = r_rd_addr;
  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign tx_busy      = r_tx_busy;
  assign tx_done      = r_tx_done;
  assign dbg_tx_state = r_tx_state;

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (tx_start && (tx_len != '0)) w_tx_next = TX_ADDR;
      TX_ADDR: w_tx_next = TX_DATA;
      TX_DATA: w_tx_next = TX_OUT;
      TX_OUT:  if (w_accept) w_tx_next = w_last ? TX_IDLE : TX_ADDR;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // The read address is loaded on entry to TX_ADDR, so the RAM samples it at the
  // end of TX_ADDR and its data is ready to capture at the end of TX_DATA.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_len   <= '0;
      r_idx      <= '0;
      r_rd_addr  <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_done  <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            if (tx_len != '0) begin
              r_tx_len  <= tx_len;
              r_idx     <= '0;
              r_rd_addr <= '0;
              r_tx_busy <= 1'b1;
            end else begin
              r_tx_done <= 1'b1;
            end
          end
        end
        TX_DATA: begin
          r_tx_data  <= rd_tx_data;
          r_tx_valid <= 1'b1;
        end
        TX_OUT: begin
          if (w_accept) begin
            r_tx_valid <= 1'b0;
            if (w_last) begin
              r_tx_busy <= 1'b0;
              r_tx_done <= 1'b1;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_rd_addr <= r_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_buffer_ctrl.sv
// Bench for mem_buffer_ctrl: Rx vector table plus directed Tx and reset sequences.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_buffer_ctrl;
  localparam int NUMBER = 8;
  localparam int AW     = 3;
  localparam int LW     = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_last = 1'b0;
  logic [7:0]    wr_rx_data;
  logic [AW-1:0] wr_rx_addr;
  logic          we_rx;
  logic          frame_ready;
  logic [LW-1:0] frame_len;
  logic          frame_ack = 1'b0;
  logic          rx_drop;
  logic          rx_overflow;
  logic          tx_start = 1'b0;
  logic [LW-1:0] tx_len = '0;
  logic [AW-1:0] rd_tx_addr;
  logic [7:0]    rd_tx_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0;
  logic          tx_busy;
  logic          tx_done;
  logic          dbg_rx_state;
  logic [1:0]    dbg_tx_state;

  mem_buffer_ctrl #(.NUMBER(NUMBER)) dut (
    .clock(clock), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
    .wr_rx_data(wr_rx_data), .wr_rx_addr(wr_rx_addr), .we_rx(we_rx),
    .frame_ready(frame_ready), .frame_len(frame_len), .frame_ack(frame_ack),
    .rx_drop(rx_drop), .rx_overflow(rx_overflow),
    .tx_start(tx_start), .tx_len(tx_len),
    .rd_tx_addr(rd_tx_addr), .rd_tx_data(rd_tx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .dbg_rx_state(dbg_rx_state), .dbg_tx_state(dbg_tx_state)
  );

  always #5 clock = ~clock;

  // TxRAM model: synchronous read, data one clock after the address.
  logic [7:0] tx_ram [0:NUMBER-1];
  always @(posedge clock) rd_tx_data <= tx_ram[rd_tx_addr];

  logic [18:0] rx_out;
  logic [35:0] all_out;
  assign rx_out  = {we_rx, wr_rx_addr, wr_rx_data, frame_ready, frame_len, rx_drop, rx_overflow};
  assign all_out = {rx_out, rd_tx_addr, tx_valid, tx_data, tx_busy, tx_done, dbg_rx_state, dbg_tx_state};

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        a;
    logic [18:0] e;
  } rx_vec_t;
  rx_vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] pk(input int we, input int ad, input int wd, input int fr,
                                     input int ln, input int dr, input int ov);
    return {we[0], ad[2:0], wd[7:0], fr[0], ln[3:0], dr[0], ov[0]};
  endfunction

  task automatic add(input int v, input int d, input int l, input int a, input logic [18:0] e);
    rx_vec_t t;
    t.v = v[0]; t.d = d[7:0]; t.l = l[0]; t.a = a[0]; t.e = e;
    tbl.push_back(t);
  endtask

  // Runs one Tx request; expected bytes are already in exp_q.
  task automatic run_tx(input int len, input int stall_byte, input int stall_n,
                        input int restart_at, input bit check_gap);
    int byte_idx = 0, stalled = 0, done_cnt = 0, acc = 0, last_acc = -1, after = 0, iter = 0;
    bit done_seen = 1'b0;
    @(posedge clock); #1;
    tx_start = 1'b1;
    tx_len   = LW'(len);
    tx_ready = !(stall_byte == 0 && stall_n > 0);
    @(posedge clock); #1;
    tx_start = 1'b0;
    while (iter < 200 && after < 6) begin
      @(negedge clock);
      if (iter == 0) check("tx_busy_start", 64'(tx_busy), 64'(len > 0));
      if (tx_valid && !tx_ready) begin
        if (byte_idx == stall_byte) stalled++;
        if (exp_q.size() > 0) check("tx_hold_data", 64'(tx_data), 64'(exp_q[0]));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("tx_extra_byte", 64'(tx_data), 64'hFFFF);
        else check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
        if (check_gap && last_acc >= 0) check("tx_gap", 64'(iter - last_acc), 64'd3);
        last_acc = iter;
        byte_idx++;
        acc++;
      end
      if (tx_done) begin
        done_cnt++;
        check("tx_busy_at_done", 64'(tx_busy), 64'd0);
        done_seen = 1'b1;
      end
      if (done_seen) after++;
      iter++;
      @(posedge clock); #1;
      tx_start = (iter == restart_at);
      tx_len   = (iter == restart_at) ? LW'(1) : '0;
      tx_ready = !(byte_idx == stall_byte && stalled < stall_n);
    end
    check("tx_done_count", 64'(done_cnt), 64'd1);
    check("tx_byte_count", 64'(acc), 64'(len));
    check("tx_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < NUMBER; i++) tx_ram[i] = 8'hA0 + 8'(i);

    // Frame accept, hold/drop, ack with same-cycle drop, ack ignored in FILL.
    add(0, 'h00, 0, 0, pk(0, 0, 'h00, 0, 0, 0, 0));
    add(1, 'h11, 0, 0, pk(1, 0, 'h11, 0, 0, 0, 0));
    add(1, 'h22, 0, 0, pk(1, 1, 'h22, 0, 0, 0, 0));
    add(1, 'h33, 1, 0, pk(1, 2, 'h33, 0, 0, 0, 0));
    add(0, 'h00, 0, 0, pk(0, 0, 'h00, 1, 3, 0, 0));
    add(1, 'h55, 0, 0, pk(0, 0, 'h00, 1, 3, 0, 0));
    add(1, 'h66, 0, 0, pk(0, 0, 'h00, 1, 3, 1, 0));
    add(1, 'h77, 0, 1, pk(0, 0, 'h00, 1, 3, 1, 0));
    add(1, 'h44, 1, 0, pk(1, 0, 'h44, 0, 3, 1, 0));
    add(0, 'h00, 0, 0, pk(0, 0, 'h00, 1, 1, 0, 0));
    add(0, 'h00, 0, 1, pk(0, 0, 'h00, 1, 1, 0, 0));
    add(0, 'h00, 0, 1, pk(0, 0, 'h00, 0, 1, 0, 0));
    add(0, 'h00, 0, 0, pk(0, 0, 'h00, 0, 1, 0, 0));
    // 9 bytes without last overflow; the 9th starts a new frame closed as 8 bytes.
    for (int k = 0; k < 16; k++)
      add(1, 'h80 + k, int'(k == 15), 0, pk(1, k % 8, 'h80 + k, 0, 1, 0, int'(k == 8)));
    add(0, 'h00, 0, 0, pk(0, 0, 'h00, 1, 8, 0, 0));

    #1 check("reset_outputs", 64'(all_out), 64'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clock); #1;
      rx_valid = tbl[i].v; rx_data = tbl[i].d; rx_last = tbl[i].l; frame_ack = tbl[i].a;
      @(negedge clock);
      check($sformatf("rx_vec%0d", i), 64'(rx_out), 64'(tbl[i].e));
    end
    @(posedge clock); #1;
    rx_valid = 1'b0; rx_last = 1'b0; frame_ack = 1'b0;

    // Tx stream at full rate.
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
    run_tx(4, -1, 0, -1, 1'b1);
    // Backpressure on the second byte with a start request while busy.
    for (int i = 0; i < 3; i++) exp_q.push_back(8'hA0 + 8'(i));
    run_tx(3, 1, 5, 3, 1'b0);
    // Zero-length request.
    run_tx(0, -1, 0, -1, 1'b0);

    // Reset while Tx is in TX_OUT and Rx holds a frame.
    tx_ready = 1'b0;
    @(posedge clock); #1;
    tx_start = 1'b1; tx_len = LW'(4);
    @(posedge clock); #1;
    tx_start = 1'b0; tx_len = '0;
    w = 0;
    while (!tx_valid && w < 10) begin
      @(negedge clock);
      w++;
    end
    check("tx_out_reached", 64'(tx_valid), 64'd1);
    check("rx_held_before_reset", 64'(frame_ready), 64'd1);
    #1 reset = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
    #1 check("reset_async_outputs", 64'(all_out), 64'd0);
    @(posedge clock); #1 rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("after_release_outputs", 64'(all_out), 64'd0);
    @(posedge clock); #1 rx_valid = 1'b1; rx_data = 8'h5A; rx_last = 1'b1;
    @(negedge clock);
    check("post_reset_write", 64'(rx_out), 64'(pk(1, 0, 'h5A, 0, 0, 0, 0)));
    @(posedge clock); #1 rx_valid = 1'b0; rx_last = 1'b0;
    @(negedge clock);
    check("post_reset_frame", 64'(rx_out), 64'(pk(0, 0, 'h00, 1, 1, 0, 0)));
    exp_q.push_back(8'hA0);
    run_tx(1, -1, 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
